mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (one per line: name, default, meaning) SHALL be:
 - ADDR_W, 32, address width.
 - DATA_W, 128, line width.
REQ-002 Ports (one per line: name  direction  width  meaning) SHALL be:
 - clk  in  1  single clock; all state updates on its rising edge.
 - reset_n  in  1  reset; one clock; reset is synchronous and active-low.
 - ic_req_valid  in  1  icache read request.
 - ic_req_addr  in  ADDR_W  icache line address.
 - ic_req_ready  out  1  icache request accepted this cycle.
 - dc_req_valid  in  1  dcache request.
 - dc_req_rw  in  1  1=write, 0=read.
 - dc_req_addr  in  ADDR_W  dcache line address.
 - dc_req_data  in  DATA_W  dcache write line.
 - dc_req_ready  out  1  dcache request accepted this cycle.
 - mem_req_valid  out  1  request to main memory.
 - mem_req_rw  out  1  latched rw.
 - mem_req_addr  out  ADDR_W  latched address.
 - mem_req_data  out  DATA_W  latched write data.
 - mem_req_ready  in  1  memory accepts request.
 - mem_resp_valid  in  1  read data returned.
 - mem_resp_data  in  DATA_W  read line.
 - ic_resp_valid  out  1  one-cycle pulse, icache read data valid.
 - dc_resp_valid  out  1  one-cycle pulse, dcache read data valid.
 - resp_data  out  DATA_W  registered copy of mem_resp_data.
 - busy  out  1  high when state is not IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE, WAIT; exactly one transaction is outstanding at any time.
REQ-004 In IDLE, if any request is valid, exactly one ready SHALL be asserted combinationally, to the granted requester; handshake is valid&ready; the transaction is latched (addr, rw, data, owner) and the next state is ISSUE.
REQ-005 Icache requests SHALL be issued with rw=0 and mem_req_data=0.
REQ-006 Arbitration without RR (see REQ-015): dcache wins when both are valid.
REQ-007 ISSUE: mem_req_valid=1 with latched fields held stable until mem_req_ready; on acceptance a write returns to IDLE with no response, and a read goes to WAIT.
REQ-008 WAIT: on mem_resp_valid, resp_data is loaded and the owner's resp_valid pulses high in the next cycle for exactly one cycle; the state returns to IDLE in that same next cycle.
REQ-009 Latency: request accepted in cycle N gives mem_req_valid in cycle N+1; mem_resp_valid in cycle M gives resp_valid in M+1; the next request may be accepted in M+1.
REQ-010 mem_resp_valid in IDLE or ISSUE SHALL be ignored with no state or output change.
REQ-011 ic_req_ready and dc_req_ready SHALL be 0 in ISSUE and WAIT regardless of valid; requests held across these states are serviced later.
REQ-012 resp_data SHALL hold its value between responses; mem_req_* SHALL be 0 when mem_req_valid=0.

Reset
REQ-013 With reset_n low at a clk edge: state=IDLE; all valid/ready/busy outputs=0; resp_data, latched addr/data/rw=0; RR pointer set so dcache has priority on the first tie.
REQ-014 Reset mid-transaction SHALL abandon it; a late mem_resp_valid after reset SHALL produce no resp_valid.

Configuration
REQ-015 Macro MEM_ARB_RR_EN: when defined, a 1-bit last-grant pointer updates on every handshake, and on a tie the requester not granted last wins; when undefined, the pointer is absent and fixed dcache priority applies.

Verification
REQ-016 Icache read 0x1000, mem_req_ready=1 immediately, response 2 cycles later with 0xA5..A5 -> mem_req_valid in N+1, ic_resp_valid one cycle with resp_data=0xA5..A5, dc_resp_valid stays 0.
REQ-017 Dcache write 0x2000 data 0x1234, mem_req_ready held low 3 cycles -> mem_req fields stable for 4 cycles, return to IDLE, no resp_valid pulse.
REQ-018 Both valid continuously, 4 reads each -> fixed priority: 4 dcache grants precede any icache grant; with MEM_ARB_RR_EN: grants alternate dc, ic, dc, ic...
REQ-019 Spurious mem_resp_valid in IDLE and ISSUE -> no resp_valid, state unchanged.
REQ-020 reset_n low for one cycle during WAIT, then mem_resp_valid -> busy=0, no resp_valid, next ic request accepted in the following cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter in front of a single-outstanding memory port.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break instead of fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_data,
    output logic              dc_req_ready,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              ic_resp_valid,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    state_t              next_state;
    logic                lat_rw;
    logic                lat_owner_dc;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                grant_dc;
    logic                grant_ic;
    logic                handshake;

`ifdef MEM_ARB_RR_EN
    // Remembers whether the last handshake went to the dcache; reset makes dcache win the first tie.
    logic last_dc;

    always_ff @(posedge clk) begin
        if (!reset_n)
            last_dc <= 1'b0;
        else if (handshake)
            last_dc <= dc_req_ready;
    end

    assign grant_dc = dc_req_valid && (!ic_req_valid || !last_dc);
`else
    assign grant_dc = dc_req_valid;
`endif

    assign grant_ic  = ic_req_valid && !grant_dc;
    assign handshake = ic_req_ready || dc_req_ready;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (handshake) next_state = ISSUE;
            ISSUE:   if (mem_req_ready) next_state = lat_rw ? IDLE : WAIT;
            WAIT:    if (mem_resp_valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Readies are held low while reset is asserted so no handshake is visible during reset.
    always_comb begin
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        busy          = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (reset_n) begin
                    ic_req_ready = grant_ic;
                    dc_req_ready = grant_dc;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = lat_rw;
                mem_req_addr  = lat_addr;
                mem_req_data  = lat_data;
            end
            default: ;
        endcase
    end

    // Icache transactions are always reads carrying zero data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_rw        <= 1'b0;
            lat_owner_dc  <= 1'b0;
            lat_addr      <= '0;
            lat_data      <= '0;
            resp_data     <= '0;
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
        end else begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            if (handshake) begin
                lat_owner_dc <= dc_req_ready;
                lat_rw       <= dc_req_ready && dc_req_rw;
                lat_addr     <= dc_req_ready ? dc_req_addr : ic_req_addr;
                lat_data     <= (dc_req_ready && dc_req_rw) ? dc_req_data : '0;
            end
            if (state == WAIT && mem_resp_valid) begin
                resp_data     <= mem_resp_data;
                ic_resp_valid <= !lat_owner_dc;
                dc_resp_valid <= lat_owner_dc;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    typedef struct {
        logic         rst_n;
        logic         ic_v;
        logic [31:0]  ic_a;
        logic         dc_v;
        logic         dc_rw;
        logic [31:0]  dc_a;
        logic [127:0] dc_d;
        logic         m_rdy;
        logic         rsp_v;
        logic [127:0] rsp_d;
    } stim_t;

    typedef struct {
        logic         ic_rdy;
        logic         dc_rdy;
        logic         m_v;
        logic         m_rw;
        logic [31:0]  m_a;
        logic [127:0] m_d;
        logic         ic_rv;
        logic         dc_rv;
        logic [127:0] r_d;
        logic         busy;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] P55 = {16{8'h55}};
    localparam logic [127:0] ALLF = {128{1'b1}};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         ic_req_valid;
    logic [31:0]  ic_req_addr;
    logic         ic_req_ready;
    logic         dc_req_valid;
    logic         dc_req_rw;
    logic [31:0]  dc_req_addr;
    logic [127:0] dc_req_data;
    logic         dc_req_ready;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic         ic_resp_valid;
    logic         dc_resp_valid;
    logic [127:0] resp_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    // Reference model: one outstanding transaction record plus pending response pulses.
    bit           m_active;
    bit           m_sent;
    bit           m_is_dc;
    bit           m_rw;
    bit [31:0]    m_addr;
    bit [127:0]   m_data;
    bit [127:0]   m_rdata;
    bit           m_pic;
    bit           m_pdc;
    bit           m_last_dc;

    mem_arbiter #(.ADDR_W(32), .DATA_W(128)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .dc_req_valid   (dc_req_valid),
        .dc_req_rw      (dc_req_rw),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_req_ready   (dc_req_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .ic_resp_valid  (ic_resp_valid),
        .dc_resp_valid  (dc_resp_valid),
        .resp_data      (resp_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic stim_t idleStim();
        stim_t s;
        s.rst_n = 1'b1;
        s.ic_v  = 1'b0;
        s.ic_a  = '0;
        s.dc_v  = 1'b0;
        s.dc_rw = 1'b0;
        s.dc_a  = '0;
        s.dc_d  = '0;
        s.m_rdy = 1'b0;
        s.rsp_v = 1'b0;
        s.rsp_d = '0;
        return s;
    endfunction

    task automatic addVec(input logic rst_n, input logic icv, input logic [31:0] ica,
                          input logic dcv, input logic dcrw, input logic [31:0] dca,
                          input logic [127:0] dcd, input logic mrdy, input logic rspv,
                          input logic [127:0] rspd, input logic eicr, input logic edcr,
                          input logic emv, input logic emrw, input logic [31:0] ema,
                          input logic [127:0] emd, input logic eicv, input logic edcv,
                          input logic [127:0] erd, input logic ebusy);
        vec_t v;
        v.s.rst_n = rst_n; v.s.ic_v = icv; v.s.ic_a = ica; v.s.dc_v = dcv;
        v.s.dc_rw = dcrw; v.s.dc_a = dca; v.s.dc_d = dcd; v.s.m_rdy = mrdy;
        v.s.rsp_v = rspv; v.s.rsp_d = rspd;
        v.e.ic_rdy = eicr; v.e.dc_rdy = edcr; v.e.m_v = emv; v.e.m_rw = emrw;
        v.e.m_a = ema; v.e.m_d = emd; v.e.ic_rv = eicv; v.e.dc_rv = edcv;
        v.e.r_d = erd; v.e.busy = ebusy;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        reset_n        = s.rst_n;
        ic_req_valid   = s.ic_v;
        ic_req_addr    = s.ic_a;
        dc_req_valid   = s.dc_v;
        dc_req_rw      = s.dc_rw;
        dc_req_addr    = s.dc_a;
        dc_req_data    = s.dc_d;
        mem_req_ready  = s.m_rdy;
        mem_resp_valid = s.rsp_v;
        mem_resp_data  = s.rsp_d;
        #1;
    endtask

    task automatic checkField(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkField({tag, ".ic_req_ready"},  ic_req_ready,  e.ic_rdy);
        checkField({tag, ".dc_req_ready"},  dc_req_ready,  e.dc_rdy);
        checkField({tag, ".mem_req_valid"}, mem_req_valid, e.m_v);
        checkField({tag, ".mem_req_rw"},    mem_req_rw,    e.m_rw);
        checkField({tag, ".mem_req_addr"},  mem_req_addr,  e.m_a);
        checkField({tag, ".mem_req_data"},  mem_req_data,  e.m_d);
        checkField({tag, ".ic_resp_valid"}, ic_resp_valid, e.ic_rv);
        checkField({tag, ".dc_resp_valid"}, dc_resp_valid, e.dc_rv);
        checkField({tag, ".resp_data"},     resp_data,     e.r_d);
        checkField({tag, ".busy"},          busy,          e.busy);
    endtask

    function automatic bit pickDc(input bit icv, input bit dcv);
        if (!dcv) return 1'b0;
        if (!icv) return 1'b1;
`ifdef MEM_ARB_RR_EN
        return !m_last_dc;
`else
        return 1'b1;
`endif
    endfunction

    function automatic exp_t modelExpect(input stim_t s);
        exp_t e;
        bit   dcw;
        e.ic_rdy = 0; e.dc_rdy = 0; e.m_v = 0; e.m_rw = 0; e.m_a = '0; e.m_d = '0;
        e.busy  = m_active;
        e.ic_rv = m_pic;
        e.dc_rv = m_pdc;
        e.r_d   = m_rdata;
        if (m_active && !m_sent) begin
            e.m_v = 1; e.m_rw = m_rw; e.m_a = m_addr; e.m_d = m_data;
        end
        if (!m_active && s.rst_n && (s.ic_v || s.dc_v)) begin
            dcw = pickDc(s.ic_v, s.dc_v);
            e.dc_rdy = dcw;
            e.ic_rdy = !dcw;
        end
        return e;
    endfunction

    task automatic modelStep(input stim_t s);
        bit dcw;
        if (!s.rst_n) begin
            m_active = 0; m_sent = 0; m_is_dc = 0; m_rw = 0; m_addr = '0; m_data = '0;
            m_rdata = '0; m_pic = 0; m_pdc = 0; m_last_dc = 0;
            return;
        end
        m_pic = 0;
        m_pdc = 0;
        if (!m_active) begin
            if (s.ic_v || s.dc_v) begin
                dcw       = pickDc(s.ic_v, s.dc_v);
                m_active  = 1;
                m_sent    = 0;
                m_is_dc   = dcw;
                m_rw      = dcw && s.dc_rw;
                m_addr    = dcw ? s.dc_a : s.ic_a;
                m_data    = (dcw && s.dc_rw) ? s.dc_d : '0;
                m_last_dc = dcw;
            end
        end else if (!m_sent) begin
            if (s.m_rdy) begin
                if (m_rw) m_active = 0;
                else      m_sent = 1;
            end
        end else if (s.rsp_v) begin
            m_rdata  = s.rsp_d;
            m_pic    = !m_is_dc;
            m_pdc    = m_is_dc;
            m_active = 0;
        end
    endtask

    task automatic doReset();
        stim_t s;
        s = idleStim();
        s.rst_n = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        modelStep(s);
    endtask

    initial begin
        stim_t s;
        int    ic_left;
        int    dc_left;
        int    n;
        bit    got_dc[8];
        bit    want_dc;

        // rst icv ica dcv rw dca dcd mrdy rspv rspd | icr dcr mv mrw ma md icrv dcrv rd busy
        addVec(0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 1, 32'h1000, 0, 0, 0, 0, 1, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,                  0, 0, 1, 0, 32'h1000, 0, 0, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, A5,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 1, 0, A5, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, ALLF,               0, 0, 0, 0, 0, 0, 0, 0, A5, 0);
        addVec(1, 0, 0, 1, 1, 32'h2000, 128'h1234, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, A5, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 32'h2000, 128'h1234, 0, 0, A5, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 128'hDEAD,          0, 0, 1, 1, 32'h2000, 128'h1234, 0, 0, A5, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 32'h2000, 128'h1234, 0, 0, A5, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,                  0, 0, 1, 1, 32'h2000, 128'h1234, 0, 0, A5, 1);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0, 0, A5, 0);
        addVec(1, 0, 0, 1, 0, 32'h4000, 0, 1, 0, 0,           0, 1, 0, 0, 0, 0, 0, 0, A5, 0);
        addVec(1, 1, 32'h5000, 1, 0, 32'h4000, 0, 1, 0, 0,    0, 0, 1, 0, 32'h4000, 0, 0, 0, A5, 1);
        addVec(1, 1, 32'h5000, 1, 0, 32'h4000, 0, 0, 1, P55,  0, 0, 0, 0, 0, 0, 0, 0, A5, 1);
        addVec(1, 1, 32'h5000, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 1, P55, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 1, 0, 32'h5000, 0, 0, 0, P55, 1);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("vec%0d", i), vecs[i].e);
        end

        // Both requesters valid until each has had four reads serviced.
        doReset();
        ic_left = 4;
        dc_left = 4;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
            s = idleStim();
            s.ic_v  = (ic_left > 0);
            s.ic_a  = 32'h100 + 32'(ic_left);
            s.dc_v  = (dc_left > 0);
            s.dc_a  = 32'h200 + 32'(dc_left);
            s.m_rdy = 1'b1;
            s.rsp_v = 1'b1;
            applyStimulus(s);
            checkField("arb_single_ready", ic_req_ready && dc_req_ready, 1'b0);
            if (dc_req_ready) begin
                dc_left--;
                got_dc[n] = 1'b1;
                n++;
            end else if (ic_req_ready) begin
                ic_left--;
                got_dc[n] = 1'b0;
                n++;
            end
        end
        checkField("arb_grant_count", n, 8);
        for (int k = 0; k < n; k++) begin
`ifdef MEM_ARB_RR_EN
            want_dc = (k % 2 == 0);
`else
            want_dc = (k < 4);
`endif
            checkField($sformatf("arb_grant%0d_is_dc", k), got_dc[k], want_dc);
        end

        // Reset during WAIT abandons the read; the late response must be ignored.
        doReset();
        s = idleStim();
        s.ic_v = 1'b1;
        s.ic_a = 32'h100;
        applyStimulus(s);
        checkField("rstwait_accept", ic_req_ready, 1'b1);
        s = idleStim();
        s.m_rdy = 1'b1;
        applyStimulus(s);
        checkField("rstwait_issue", mem_req_valid, 1'b1);
        s = idleStim();
        s.rst_n = 1'b0;
        applyStimulus(s);
        checkField("rstwait_busy_in_wait", busy, 1'b1);
        s = idleStim();
        s.rsp_v = 1'b1;
        s.rsp_d = A5;
        applyStimulus(s);
        checkField("rstwait_busy_after_reset", busy, 1'b0);
        checkField("rstwait_no_ic_resp0", ic_resp_valid, 1'b0);
        s = idleStim();
        s.ic_v = 1'b1;
        s.ic_a = 32'h200;
        applyStimulus(s);
        checkField("rstwait_no_ic_resp1", ic_resp_valid, 1'b0);
        checkField("rstwait_no_dc_resp1", dc_resp_valid, 1'b0);
        checkField("rstwait_resp_data", resp_data, 128'h0);
        checkField("rstwait_next_accept", ic_req_ready, 1'b1);
        s = idleStim();
        applyStimulus(s);
        checkField("rstwait_next_addr", mem_req_addr, 32'h200);

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(0, 39) != 0);
            s.ic_v  = ($urandom_range(0, 9) < 6);
            s.ic_a  = $urandom();
            s.dc_v  = ($urandom_range(0, 9) < 6);
            s.dc_rw = $urandom_range(0, 1) == 1;
            s.dc_a  = $urandom();
            s.dc_d  = {$urandom(), $urandom(), $urandom(), $urandom()};
            s.m_rdy = $urandom_range(0, 1) == 1;
            s.rsp_v = ($urandom_range(0, 9) < 3);
            s.rsp_d = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(s);
            checkOutput($sformatf("rand%0d", i), modelExpect(s));
            modelStep(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
